// File: rtl/modulo_pkg.sv
// ============================================================================
//  Module      : modulo_pkg
//  Description : Shared types and helpers for the modulo folding path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package modulo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Real-valued threshold to a raw fixed-point code, evaluated at elaboration.
    function automatic longint to_fixed(input real value, input int frac_bits);
        return longint'(value * real'(longint'(1) << frac_bits));
    endfunction

    function automatic longint double_lambda(input longint lambda);
        return 2 * lambda;
    endfunction

endpackage : modulo_pkg

`default_nettype wire

// File: rtl/modulo_fold_if.sv
// ============================================================================
//  Module      : modulo_fold_if
//  Description : Sample handshake and result bus of modulo_fold.
//                eps_out exists only when MODULO_FOLD_EPS_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface modulo_fold_if #(
    parameter int WIDTH = 32
);
    logic                    valid_in;
    logic                    ready;
    logic signed [WIDTH-1:0] x_in;
    logic                    valid_out;
    logic signed [WIDTH-1:0] fold_out;
    logic signed [WIDTH-1:0] fold_count;
`ifdef MODULO_FOLD_EPS_EN
    logic signed [WIDTH-1:0] eps_out;

    modport master (
        output valid_in, x_in,
        input  ready, valid_out, fold_out, fold_count, eps_out
    );
    modport slave (
        input  valid_in, x_in,
        output ready, valid_out, fold_out, fold_count, eps_out
    );
`else
    modport master (
        output valid_in, x_in,
        input  ready, valid_out, fold_out, fold_count
    );
    modport slave (
        input  valid_in, x_in,
        output ready, valid_out, fold_out, fold_count
    );
`endif

endinterface : modulo_fold_if

`default_nettype wire

// File: rtl/seq_udiv.sv
// ============================================================================
//  Module      : seq_udiv
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                enabled cycle; the start cycle already performs bit one.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_udiv #(
    parameter int N = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int c_CW = $clog2(N + 1);

    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_quot;
    logic [N-1:0]    r_div;
    logic [c_CW-1:0] r_count;
    logic            r_busy;
    logic            r_done;

    logic [N-1:0] w_rem_in;
    logic [N-1:0] w_quot_in;
    logic [N-1:0] w_div;
    logic [N:0]   w_trial;
    logic [N-1:0] w_rem_nxt;
    logic [N-1:0] w_quot_nxt;

    // Start folds the load into the first step so N steps end N-1 edges later.
    always_comb begin
        w_rem_in  = start ? '0       : r_rem;
        w_quot_in = start ? dividend : r_quot;
        w_div     = start ? divisor  : r_div;
        w_trial   = {w_rem_in, w_quot_in[N-1]};
        if (w_trial >= {1'b0, w_div}) begin
            w_rem_nxt  = N'(w_trial - {1'b0, w_div});
            w_quot_nxt = {w_quot_in[N-2:0], 1'b1};
        end else begin
            w_rem_nxt  = N'(w_trial);
            w_quot_nxt = {w_quot_in[N-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (clk_en) begin
            if (start) begin
                r_rem   <= w_rem_nxt;
                r_quot  <= w_quot_nxt;
                r_div   <= divisor;
                r_count <= c_CW'(1);
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else if (r_busy) begin
                r_rem   <= w_rem_nxt;
                r_quot  <= w_quot_nxt;
                r_count <= r_count + 1'b1;
                if (r_count == c_CW'(N - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;

endmodule : seq_udiv

`default_nettype wire

// File: rtl/modulo_fold.sv
// ============================================================================
//  Module      : modulo_fold
//  Description : Centered-modulo folder y = ((x + L) mod 2L) - L with fold
//                count k. MODULO_FOLD_EPS_EN adds the eps_out residual port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module modulo_fold
    import modulo_pkg::*;
#(
    parameter int     WIDTH           = 32,
    parameter int     FRACTIONAL_BITS = 20,
    parameter longint LAMBDA          = to_fixed(0.75, FRACTIONAL_BITS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clk_en,
    modulo_fold_if.slave bus
);

    if (LAMBDA <= 0 || 2 * LAMBDA >= (longint'(1) << (WIDTH - 1))) begin : g_bad_lambda
        $error("modulo_fold: LAMBDA out of range for WIDTH");
    end

    localparam longint          c_DIV_FULL = double_lambda(LAMBDA);
    localparam logic [WIDTH:0]  c_LAMBDA   = LAMBDA[WIDTH:0];
    localparam logic [WIDTH:0]  c_DIVISOR  = c_DIV_FULL[WIDTH:0];

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_x;
    logic                    r_sign;
    logic                    r_ready;
    logic                    r_valid_out;
    logic signed [WIDTH-1:0] r_fold;
    logic signed [WIDTH-1:0] r_fold_count;

    logic [WIDTH:0]          w_v;
    logic [WIDTH:0]          w_mag;
    logic                    w_div_start;
    logic                    w_div_done;
    logic [WIDTH:0]          w_quot;
    logic [WIDTH:0]          w_rem;
    logic [WIDTH:0]          w_rem_fix;
    logic [WIDTH:0]          w_k;
    logic signed [WIDTH-1:0] w_fold;

    // 2L < 2^(WIDTH-1), so one extra bit holds x + L without overflow.
    assign w_v         = {r_x[WIDTH-1], r_x} + c_LAMBDA;
    assign w_mag       = w_v[WIDTH] ? -w_v : w_v;
    assign w_div_start = (r_state == PREP);

    seq_udiv #(
        .N (WIDTH + 1)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .start     (w_div_start),
        .dividend  (w_mag),
        .divisor   (c_DIVISOR),
        .done      (w_div_done),
        .quotient  (w_quot),
        .remainder (w_rem)
    );

    // Negative v: floor division needs one more fold unless it divided exactly.
    always_comb begin
        w_rem_fix = w_rem;
        w_k       = w_quot;
        if (r_sign) begin
            if (w_rem == '0) begin
                w_rem_fix = '0;
                w_k       = -w_quot;
            end else begin
                w_rem_fix = c_DIVISOR - w_rem;
                w_k       = ~w_quot;
            end
        end
    end

    assign w_fold = WIDTH'(w_rem_fix - c_LAMBDA);

`ifdef MODULO_FOLD_EPS_EN
    logic signed [WIDTH-1:0] r_eps;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_eps <= '0;
        end else if (clk_en && r_state == FIX) begin
            r_eps <= w_fold - r_x;
        end
    end

    assign bus.eps_out = r_eps;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_sign       <= 1'b0;
            r_ready      <= 1'b1;
            r_valid_out  <= 1'b0;
            r_fold       <= '0;
            r_fold_count <= '0;
        end else if (clk_en) begin
            r_valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.valid_in) begin
                        r_x     <= bus.x_in;
                        r_ready <= 1'b0;
                        r_state <= PREP;
                    end
                end
                PREP: begin
                    r_sign  <= w_v[WIDTH];
                    r_state <= DIV;
                end
                DIV: begin
                    if (w_div_done) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_fold       <= w_fold;
                    r_fold_count <= WIDTH'(w_k);
                    r_valid_out  <= 1'b1;
                    r_ready      <= 1'b1;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.valid_out  = r_valid_out;
    assign bus.fold_out   = r_fold;
    assign bus.fold_count = r_fold_count;

endmodule : modulo_fold

`default_nettype wire
